// File: rtl/fifo_word_packer_if.sv
// Bundle of the FIFO read port and the packed-word valid/ready stream for fifo_word_packer.
// FIFO_WORD_PACKER_FLUSH_EN adds the flush request and the m_keep byte mask.
interface fifo_word_packer_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned WORDS = 4
);
    logic                  fifo_empty;
    logic [DW-1:0]         rd_data;
    logic                  rden;
    logic [DW*WORDS-1:0]   m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  ovf_err;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    logic                  flush;
    logic [WORDS-1:0]      m_keep;

    modport master (
        input  fifo_empty, rd_data, m_ready, flush,
        output rden, m_data, m_valid, ovf_err, m_keep
    );
    modport slave (
        output fifo_empty, rd_data, m_ready, flush,
        input  rden, m_data, m_valid, ovf_err, m_keep
    );
`else
    modport master (
        input  fifo_empty, rd_data, m_ready,
        output rden, m_data, m_valid, ovf_err
    );
    modport slave (
        output fifo_empty, rd_data, m_ready,
        input  rden, m_data, m_valid, ovf_err
    );
`endif
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a FIFO read port (RD_LAT read latency) and packs them into WORDS-byte words.
// Define FIFO_WORD_PACKER_FLUSH_EN to add flush/m_keep for emitting zero-padded partial words.
module fifo_word_packer #(
    parameter int unsigned DW     = 8,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input logic                rdclk,
    input logic                rdrst,
    fifo_word_packer_if.master bus
);
    localparam int unsigned   CW      = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LastIdx = CW'(WORDS - 1);
    localparam logic [CW-1:0] FullCnt = CW'(WORDS);
    localparam logic [CW:0]   WordsW  = (CW + 1)'(WORDS);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e              state_q;
    logic [CW-1:0]       asm_cnt_q;
    logic [RD_LAT-1:0]   lat_pipe_q;
    logic [DW*WORDS-1:0] asm_buf_q;
    logic [DW*WORDS-1:0] m_data_q;
    logic                m_valid_q;
    logic                ovf_err_q;

    logic [DW*WORDS-1:0] asm_word;
    logic [CW-1:0]       inflight;
    logic                pipe_out;
    logic                out_free;
    logic                rden_c;
    logic                flush_pend;

`ifdef FIFO_WORD_PACKER_FLUSH_EN
    logic                flush_pend_q;
    logic [WORDS-1:0]    m_keep_q;
    logic [WORDS-1:0]    part_keep;

    always_comb begin
        part_keep = '0;
        for (int k = 0; k < WORDS; k++) begin
            part_keep[k] = (CW'(k) < asm_cnt_q);
        end
    end

    assign flush_pend = flush_pend_q;
    assign bus.m_keep = m_keep_q;
`else
    assign flush_pend = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(lat_pipe_q[i]);
        end
    end

    // Assembly image with the returning byte already merged into its slot.
    always_comb begin
        asm_word = asm_buf_q;
        for (int k = 0; k < WORDS; k++) begin
            if (asm_cnt_q == CW'(k)) asm_word[k*DW +: DW] = bus.rd_data;
        end
    end

    assign pipe_out = lat_pipe_q[RD_LAT-1];
    assign out_free = !m_valid_q || bus.m_ready;
    assign rden_c   = !bus.fifo_empty && !rdrst && (state_q == StFill) && !flush_pend &&
                      (({1'b0, asm_cnt_q} + {1'b0, inflight}) < WordsW);

    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            state_q    <= StFill;
            asm_cnt_q  <= '0;
            lat_pipe_q <= '0;
            asm_buf_q  <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
            flush_pend_q <= 1'b0;
            m_keep_q     <= '0;
`endif
        end else begin
            lat_pipe_q[0] <= rden_c;
            for (int i = 1; i < RD_LAT; i++) lat_pipe_q[i] <= lat_pipe_q[i-1];
            if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
            if (pipe_out && asm_cnt_q == FullCnt) ovf_err_q <= 1'b1;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
            if (bus.flush && (asm_cnt_q != '0 || inflight != '0)) flush_pend_q <= 1'b1;
`endif
            unique case (state_q)
                StFill: begin
                    if (pipe_out) begin
                        // Last byte goes straight to the output when it is free.
                        if (asm_cnt_q == LastIdx && out_free) begin
                            m_data_q  <= asm_word;
                            m_valid_q <= 1'b1;
                            asm_buf_q <= '0;
                            asm_cnt_q <= '0;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
                            m_keep_q  <= '1;
`endif
                        end else begin
                            asm_buf_q <= asm_word;
                            asm_cnt_q <= asm_cnt_q + CW'(1);
                            if (asm_cnt_q == LastIdx) state_q <= StFull;
                        end
                    end
`ifdef FIFO_WORD_PACKER_FLUSH_EN
                    else if (flush_pend_q && inflight == '0) begin
                        if (asm_cnt_q == '0) begin
                            flush_pend_q <= 1'b0;
                        end else if (out_free) begin
                            m_data_q     <= asm_buf_q;
                            m_keep_q     <= part_keep;
                            m_valid_q    <= 1'b1;
                            asm_buf_q    <= '0;
                            asm_cnt_q    <= '0;
                            flush_pend_q <= 1'b0;
                        end
                    end
`endif
                end
                StFull: begin
                    if (out_free) begin
                        m_data_q  <= asm_buf_q;
                        m_valid_q <= 1'b1;
                        asm_buf_q <= '0;
                        asm_cnt_q <= '0;
                        state_q   <= StFill;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
                        m_keep_q  <= '1;
`endif
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign bus.rden    = rden_c;
    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign bus.ovf_err = ovf_err_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: RD_LAT=1 and RD_LAT=2 instances fed by FIFO models.
module tb_fifo_word_packer;
    localparam int unsigned DW    = 8;
    localparam int unsigned WORDS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst2;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fifo_word_packer_if #(.DW(DW), .WORDS(WORDS)) bus1 ();
    fifo_word_packer_if #(.DW(DW), .WORDS(WORDS)) bus2 ();

    fifo_word_packer #(.DW(DW), .WORDS(WORDS), .RD_LAT(1)) dut1 (
        .rdclk(clk), .rdrst(rst1), .bus(bus1)
    );
    fifo_word_packer #(.DW(DW), .WORDS(WORDS), .RD_LAT(2)) dut2 (
        .rdclk(clk), .rdrst(rst2), .bus(bus2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FIFO models: byte arrays with write/read counters.
    logic [7:0]  mem1 [0:63];
    logic [7:0]  mem2 [0:63];
    int unsigned pw1 = 0, pr1 = 0, pw2 = 0, pr2 = 0;
    logic [7:0]  stg2;

    assign bus1.fifo_empty = (pw1 == pr1);
    assign bus2.fifo_empty = (pw2 == pr2);

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (bus1.rden && pw1 != pr1) begin
            bus1.rd_data <= mem1[pr1[5:0]];
            pr1 <= pr1 + 1;
        end
        if (bus2.rden && pw2 != pr2) begin
            stg2 <= mem2[pr2[5:0]];
            pr2  <= pr2 + 1;
        end
        bus2.rd_data <= stg2;
    end

    // Scoreboard: expected words are built from the bytes as they are pushed.
    logic [31:0] exp1 [$];
    logic [31:0] exp2 [$];
    logic [3:0]  expk1 [$];
    logic [31:0] acc1 = '0, acc2 = '0;
    int          an1 = 0, an2 = 0;

    task automatic push1(input logic [7:0] b);
        mem1[pw1[5:0]] = b;
        pw1++;
        acc1[an1*8 +: 8] = b;
        an1++;
        if (an1 == WORDS) begin
            exp1.push_back(acc1);
            expk1.push_back(4'hF);
            an1  = 0;
            acc1 = '0;
        end
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[pw2[5:0]] = b;
        pw2++;
        acc2[an2*8 +: 8] = b;
        an2++;
        if (an2 == WORDS) begin
            exp2.push_back(acc2);
            an2  = 0;
            acc2 = '0;
        end
    endtask

    int          rx1 = 0, rx2 = 0, vcyc1 = 0;
    int          rden_cyc1 = 0, valid_cyc1 = 0;
    bit          rden_seen1 = 0, valid_seen1 = 0;
    bit          hold1 = 0, hold2 = 0;
    logic [31:0] hd1, hd2;
    int          acc_cyc1 [$];

    initial forever begin
        @(negedge clk);
        if (rst1) begin
            hold1 = 0;
        end else begin
            if (bus1.rden && !rden_seen1) begin
                rden_seen1 = 1;
                rden_cyc1  = cyc;
            end
            if (bus1.m_valid) begin
                vcyc1++;
                if (!valid_seen1) begin
                    valid_seen1 = 1;
                    valid_cyc1  = cyc;
                end
            end
            if (hold1) begin
                check_eq("hold_valid1", 64'(bus1.m_valid), 64'd1);
                check_eq("hold_data1", 64'(bus1.m_data), 64'(hd1));
            end
            if (bus1.m_valid && bus1.m_ready) begin
                if (exp1.size() == 0) begin
                    check_eq("word1_expected", 64'(exp1.size()), 64'd1);
                end else begin
                    check_eq("word1", 64'(bus1.m_data), 64'(exp1.pop_front()));
`ifdef FIFO_WORD_PACKER_FLUSH_EN
                    check_eq("keep1", 64'(bus1.m_keep), 64'(expk1.pop_front()));
`endif
                end
                rx1++;
                acc_cyc1.push_back(cyc);
            end
            hold1 = bus1.m_valid && !bus1.m_ready;
            hd1   = bus1.m_data;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst2) begin
            hold2 = 0;
        end else begin
            if (hold2) begin
                check_eq("hold_valid2", 64'(bus2.m_valid), 64'd1);
                check_eq("hold_data2", 64'(bus2.m_data), 64'(hd2));
            end
            if (bus2.m_valid && bus2.m_ready) begin
                if (exp2.size() == 0) begin
                    check_eq("word2_expected", 64'(exp2.size()), 64'd1);
                end else begin
                    check_eq("word2", 64'(bus2.m_data), 64'(exp2.pop_front()));
                end
                rx2++;
            end
            hold2 = bus2.m_valid && !bus2.m_ready;
            hd2   = bus2.m_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx1(input int n, input int budget);
        int k = 0;
        while (rx1 < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq("rx1_count", 64'(rx1), 64'(n));
    endtask

    initial begin
        int v0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.m_ready = 1'b0;
        bus2.m_ready = 1'b0;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
        bus1.flush = 1'b0;
        bus2.flush = 1'b0;
`endif
        tick(3);
        check_eq("rst_valid", 64'(bus1.m_valid), 64'd0);
        check_eq("rst_data", 64'(bus1.m_data), 64'd0);
        check_eq("rst_rden", 64'(bus1.rden), 64'd0);
        check_eq("rst_ovf", 64'(bus1.ovf_err), 64'd0);
        rst1 = 1'b0;
        rst2 = 1'b0;
        tick(2);

        // Single word, free-flowing output.
        bus1.m_ready = 1'b1;
        push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
        wait_rx1(1, 50);
        check_eq("first_latency", 64'(valid_cyc1 - rden_cyc1), 64'(WORDS + 1));
        tick(5);
        check_eq("valid_cycles", 64'(vcyc1), 64'd1);

        // Backpressure: output holds word 1, assembly fills, pops stall.
        bus1.m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push1(8'(i));
        tick(30);
        check_eq("stall_valid", 64'(bus1.m_valid), 64'd1);
        check_eq("stall_data", 64'(bus1.m_data), 64'h04030201);
        check_eq("stall_rden", 64'(bus1.rden), 64'd0);
        check_eq("stall_left", 64'(pw1 - pr1), 64'd4);
        bus1.m_ready = 1'b1;
        wait_rx1(4, 60);
        check_eq("b2b_gap", 64'(acc_cyc1[2] - acc_cyc1[1]), 64'd1);

        // Empty gap in the middle of a word.
        tick(5);
        v0 = vcyc1;
        push1(8'hAA); push1(8'hBB);
        tick(20);
        check_eq("gap_valid", 64'(vcyc1 - v0), 64'd0);
        push1(8'hCC); push1(8'hDD);
        wait_rx1(5, 50);

        // Reset mid-word drops the partial bytes.
        push1(8'hE1); push1(8'hE2); push1(8'hE3);
        tick(10);
        rst1 = 1'b1;
        an1  = 0;
        acc1 = '0;
        tick(2);
        check_eq("rst2_valid", 64'(bus1.m_valid), 64'd0);
        check_eq("rst2_data", 64'(bus1.m_data), 64'd0);
        rst1 = 1'b0;
        tick(1);
        push1(8'h5A); push1(8'h6B); push1(8'h7C); push1(8'h8D);
        wait_rx1(6, 50);

`ifdef FIFO_WORD_PACKER_FLUSH_EN
        // Flush of a two-byte partial word.
        push1(8'h12); push1(8'h34);
        tick(10);
        exp1.push_back(32'h00003412);
        expk1.push_back(4'b0011);
        an1  = 0;
        acc1 = '0;
        bus1.flush = 1'b1;
        tick(1);
        bus1.flush = 1'b0;
        wait_rx1(7, 50);
`endif

        // RD_LAT=2 stream with random backpressure.
        for (int i = 0; i < 16; i++) push2(8'(i));
        begin
            int k = 0;
            while (rx2 < 4 && k < 400) begin
                bus2.m_ready = 1'($urandom_range(0, 1));
                tick(1);
                k++;
            end
        end
        bus2.m_ready = 1'b0;
        check_eq("rx2_count", 64'(rx2), 64'd4);
        check_eq("ovf2", 64'(bus2.ovf_err), 64'd0);
        check_eq("ovf1", 64'(bus1.ovf_err), 64'd0);
        check_eq("exp1_left", 64'(exp1.size()), 64'd0);
        check_eq("exp2_left", 64'(exp2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
